// File: rtl/fifo_stream_out.sv
// FX2LP EP2 stream-out reader: drains the slave FIFO into a FWFT buffer and a valid/ready stream.
// Optional STREAM_OUT_STATS_EN adds saturating rx_count and stall_count outputs.
module fifo_stream_out #(
    parameter int DEPTH       = 16,
    parameter int STOP_MARGIN = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 fdata,
    input  logic                       flaga,
    output logic                       clk_o,
    output logic [1:0]                 faddr,
    output logic                       sloe,
    output logic                       slrd,
    output logic                       slwr,
    output logic                       pkt_end,
    output logic [7:0]                 m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH+1)-1:0] level
`ifdef STREAM_OUT_STATS_EN
    ,
    output logic [15:0]                rx_count,
    output logic [15:0]                stall_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    // Reads continue only while free entries exceed the margin (level below this limit).
    localparam logic [LW-1:0] RunLimit = LW'(DEPTH - STOP_MARGIN);

    typedef enum logic [1:0] {StIdle, StOe, StRead} state_e;

    state_e        state_q, state_d;
    logic          sloe_q, slrd_q;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          go, push, pop;

    assign go   = flaga && (level_q < RunLimit);
    assign push = !slrd_q && flaga;
    assign pop  = (level_q != '0) && m_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (go) state_d = StOe;
            StOe:    state_d = go ? StRead : StIdle;
            StRead:  state_d = go ? StRead : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Strobes are registered copies of the next state so they change exactly at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sloe_q  <= 1'b1;
            slrd_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            sloe_q  <= (state_d == StIdle);
            slrd_q  <= (state_d != StRead);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      level_q <= level_q + 1'b1;
            else if (!push && pop) level_q <= level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= fdata;
    end

`ifdef STREAM_OUT_STATS_EN
    logic [15:0] rx_q, stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q    <= '0;
            stall_q <= '0;
        end else begin
            if (push && rx_q != 16'hFFFF) rx_q <= rx_q + 1'b1;
            if (m_valid && !m_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 1'b1;
        end
    end

    assign rx_count    = rx_q;
    assign stall_count = stall_q;
`endif

    assign clk_o   = clk;
    assign faddr   = 2'b00;
    assign slwr    = 1'b1;
    assign pkt_end = 1'b1;
    assign sloe    = sloe_q;
    assign slrd    = slrd_q;
    assign m_data  = mem_q[rd_ptr_q];
    assign m_valid = (level_q != '0);
    assign level   = level_q;

endmodule

// File: tb/tb_fifo_stream_out.sv
// Self-checking bench for fifo_stream_out against a queue-based protocol model.
module tb_fifo_stream_out;

    localparam int DEPTH       = 16;
    localparam int STOP_MARGIN = 2;
    localparam int LW          = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    fdata;
    logic          flaga;
    logic          clk_o;
    logic [1:0]    faddr;
    logic          sloe, slrd, slwr, pkt_end;
    logic [7:0]    m_data;
    logic          m_valid;
    logic          m_ready;
    logic [LW-1:0] level;
`ifdef STREAM_OUT_STATS_EN
    logic [15:0]   rx_count, stall_count;
`endif

    fifo_stream_out #(.DEPTH(DEPTH), .STOP_MARGIN(STOP_MARGIN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fdata       (fdata),
        .flaga       (flaga),
        .clk_o       (clk_o),
        .faddr       (faddr),
        .sloe        (sloe),
        .slrd        (slrd),
        .slwr        (slwr),
        .pkt_end     (pkt_end),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .level       (level)
`ifdef STREAM_OUT_STATS_EN
        ,
        .rx_count    (rx_count),
        .stall_count (stall_count)
`endif
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    // Model: bus phase 0=idle, 1=output-enabled turnaround, 2=reading; q holds buffered bytes.
    int         phase = 0;
    logic [7:0] q[$];
    int         exp_rx = 0;
    int         exp_stall = 0;
    logic       last_push = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic verify();
        check("sloe", 32'(sloe), 32'(phase == 0));
        check("slrd", 32'(slrd), 32'(phase != 2));
        check("level", 32'(level), 32'(q.size()));
        check("m_valid", 32'(m_valid), 32'(q.size() > 0));
        if (q.size() > 0) check("m_data", 32'(m_data), 32'(q[0]));
`ifdef STREAM_OUT_STATS_EN
        check("rx_count", 32'(rx_count), 32'(exp_rx));
        check("stall_count", 32'(stall_count), 32'(exp_stall));
`endif
    endtask

    task automatic step();
        int   sz;
        logic go_m, push_m, pop_m;
        @(posedge clk);
        sz     = q.size();
        go_m   = flaga && ((DEPTH - sz) > STOP_MARGIN);
        push_m = (phase == 2) && flaga;
        pop_m  = (sz > 0) && m_ready;
        if (push_m && exp_rx < 65535) exp_rx++;
        if (sz > 0 && !m_ready && exp_stall < 65535) exp_stall++;
        if (pop_m) void'(q.pop_front());
        if (push_m) q.push_back(fdata);
        case (phase)
            0:       if (go_m) phase = 1;
            default: phase = go_m ? 2 : 0;
        endcase
        last_push = push_m;
        #1;
        verify();
    endtask

    // Incrementing source: the FX2 FIFO advances to the next byte after each accepted read.
    task automatic run_inc(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            if (last_push) fdata = fdata + 8'd1;
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        flaga   = 1'b0;
        m_ready = 1'b0;
        fdata   = 8'h00;
        #12;
        check("rst_sloe", 32'(sloe), 32'd1);
        check("rst_slrd", 32'(slrd), 32'd1);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("faddr", 32'(faddr), 32'd0);
        check("slwr", 32'(slwr), 32'd1);
        check("pkt_end", 32'(pkt_end), 32'd1);
        check("clk_o", 32'(clk_o), 32'(clk));
        rst_n = 1'b1;

        // EP2 empty: bus must stay idle.
        for (int i = 0; i < 10; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            step();
        end

        // Continuous streaming with incrementing data.
        flaga   = 1'b1;
        m_ready = 1'b1;
        run_inc(40);

        // Backpressure: buffer fills to the stop margin plus the in-flight word.
        m_ready = 1'b0;
        run_inc(30);
        check("fill_level", 32'(level), 32'd15);
        check("fill_slrd", 32'(slrd), 32'd1);
        m_ready = 1'b1;
        run_inc(40);

        // EP2 runs empty for 3 cycles mid-read.
        run_inc(10);
        flaga = 1'b0;
        run_inc(3);
        flaga = 1'b1;
        run_inc(10);

        // Asynchronous reset with 8 bytes buffered.
        m_ready = 1'b0;
        for (int i = 0; i < 40 && q.size() < 8; i++) begin
            step();
            if (last_push) fdata = fdata + 8'd1;
        end
        check("reach_level8", 32'(q.size()), 32'd8);
        rst_n = 1'b0;
        #2;
        check("arst_sloe", 32'(sloe), 32'd1);
        check("arst_slrd", 32'(slrd), 32'd1);
        check("arst_level", 32'(level), 32'd0);
        check("arst_m_valid", 32'(m_valid), 32'd0);
        q.delete();
        phase     = 0;
        exp_rx    = 0;
        exp_stall = 0;
        #3;
        rst_n   = 1'b1;
        m_ready = 1'b1;
        run_inc(30);

        // Randomized flag, backpressure and data.
        for (int i = 0; i < 400; i++) begin
            flaga   = ($urandom_range(0, 3) != 0);
            m_ready = 1'($urandom_range(0, 1));
            fdata   = 8'($urandom);
            step();
        end

        // Drain.
        flaga   = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 25; i++) step();
        check("drained_level", 32'(level), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_stream_out.md
Name: fifo_stream_out

Overview:
- Stream-OUT companion to the EP6 stream-in writer: drains host-to-device data from FX2LP EP2 over the synchronous slave-FIFO interface, with IFCLK driven from clk.
- Drives FIFOADR, SLOE and SLRD.
- Buffers bytes in an internal first-word-fall-through FIFO and presents them to FPGA logic on a valid/ready stream.
- Holds SLWR and PKTEND inactive, because this block never writes to the FX2LP.

Parameters:
DEPTH, 16, internal buffer depth in bytes; power of two, minimum 4.
STOP_MARGIN, 2, free-entry threshold; reads pause when free entries <= STOP_MARGIN, which covers the in-flight word.

Ports:
clk  input  1  system clock, also forwarded as IFCLK
rst_n  input  1  reset, asynchronous, active-low
fdata  input  8  FX2LP FD[7:0] read data
flaga  input  1  EP2 empty flag, active-low (1 = EP2 has data)
clk_o  output  1  IFCLK, equal to clk
faddr  output  2  FIFOADR, constant 2'b00 (EP2)
sloe  output  1  FX2LP output enable, active-low, registered
slrd  output  1  read strobe, active-low, registered
slwr  output  1  constant 1
pkt_end  output  1  constant 1
m_data  output  8  head byte of the internal buffer
m_valid  output  1  buffer not empty
m_ready  input  1  downstream accepts m_data
level  output  $clog2(DEPTH+1)  current buffer occupancy

Behaviour:
- One clock, clk. Asynchronous active-low reset on rst_n.
- Reset values: sloe=1, slrd=1, m_valid=0, level=0, state=IDLE. Buffer pointers are cleared; m_data is don't-care.
- free = DEPTH - level.
- FSM states and transitions:
  - IDLE: sloe=1, slrd=1. If flaga==1 and free > STOP_MARGIN, go to OE and drive sloe<=0.
  - OE: one bus-turnaround cycle with sloe=0, slrd=1. If the conditions still hold, go to READ and drive slrd<=0. Otherwise go to IDLE and drive sloe<=1.
  - READ: sloe=0, slrd=0. Stay in READ while flaga==1 and free > STOP_MARGIN. When either condition fails, go to IDLE; slrd and sloe both return to 1 at the next edge.
- Push rule: on a rising edge where the registered slrd==0 and flaga==1, fdata is written into the buffer. If slrd==0 and flaga==0 (EP2 ran empty), no push occurs and the FSM goes to IDLE.
- Pop rule: on a rising edge with m_valid && m_ready, the head is removed.
- Simultaneous push and pop: level is unchanged and both operations take effect.
- Latency: a byte sampled at edge E appears on m_data with m_valid=1 after edge E, i.e. one cycle of latency.
- Ordering: bytes leave in strict arrival order. No byte is dropped or duplicated.
- Pointers wrap modulo DEPTH. level never exceeds DEPTH; overflow cannot occur given STOP_MARGIN >= 1.
- Pop while empty is ignored.
- m_data must remain stable while m_valid=1 and m_ready=0.
- Reset asserted mid-READ: slrd and sloe go to 1 immediately (asynchronously), buffer contents are discarded, and the FSM returns to IDLE.

Optional Feature:
- Macro: STREAM_OUT_STATS_EN.
- Defined:
  - Adds output rx_count[15:0], which increments by 1 on every push and saturates at 16'hFFFF.
  - Adds output stall_count[15:0], which increments on each cycle with m_valid=1 and m_ready=0, also saturating.
  - Both counters are cleared by rst_n.
- Undefined: neither port exists. Core behaviour is identical in both cases.

Test Plan:
- Reset, then flaga=1 with m_ready=1 and fdata incrementing from 8'h00: sloe falls one cycle before slrd, and m_data delivers 00,01,02,... in order with no gaps once streaming.
- flaga=0 throughout: sloe=1 and slrd=1 forever; m_valid=0 and level=0.
- m_ready=0, flaga=1, DEPTH=16, STOP_MARGIN=2: level stops at 14 or 15 and never exceeds 16, and slrd returns to 1. Raising m_ready resumes reads and emits all bytes in order.
- flaga drops to 0 for 3 cycles mid-READ: no push occurs while flaga=0 and the FSM passes through IDLE then OE. The resulting byte sequence has no duplicates.
- rst_n pulsed low mid-stream with level=8: slrd and sloe go to 1 asynchronously and level=0; after release, streaming restarts cleanly.
- STREAM_OUT_STATS_EN defined, 100 bytes pushed, m_ready held low for 5 cycles with m_valid=1: rx_count=100 and stall_count=5.
